// File: rtl/cla_pkg.sv
// Shared configuration for the pipelined carry-lookahead adder.
//   DEFAULT_WIDTH / DEFAULT_SLICE : default operand width and lookahead slice width
//   check_cfg(width, slice)       : true when width is a non-zero multiple of slice
package cla_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_SLICE = 4;

    function automatic bit check_cfg(input int unsigned width, input int unsigned slice);
        return (slice != 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// One combinational carry-lookahead slice.
//   a, b      : slice operands (b already conditioned for subtraction)
//   cin       : carry into bit 0 of the slice
//   s         : slice sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (used for signed overflow in the last slice)
module cla_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Written as a recurrence; synthesis flattens it into two-level lookahead terms.
    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < SLICE; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s        = p ^ c[SLICE-1:0];
    assign cout     = c[SLICE];
    assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one SLICE-bit slice resolved per stage.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, ci, sub)
//   out_valid/out_ready : result handshake (s, co, ovf)
//   sub=1 computes a - b - ci; co=1 then means "no borrow"; ovf is signed overflow.
// Stage k register holds the beat with slices 0..k-1 already summed and the carry into
// slice k; slice k is resolved combinationally and the result moves into stage k+1.
// The last stage drives the outputs directly, giving a latency of STAGES cycles.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / SLICE;

    if (!check_cfg(WIDTH, SLICE)) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of SLICE");
    end

    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0]            carry_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] be_q;
    logic [STAGES-1:0][WIDTH-1:0] sp_q;
    logic [STAGES-1:0][WIDTH-1:0] sp_d;

    logic [STAGES-1:0][SLICE-1:0] slice_s;
    logic [STAGES-1:0]            slice_cout;
    logic [STAGES-1:0]            slice_cmsb;

    logic advance;

    // Global stall: the whole pipe moves or the whole pipe holds.
    assign out_valid = valid_q[STAGES-1];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a        (a_q[k][k*SLICE +: SLICE]),
            .b        (be_q[k][k*SLICE +: SLICE]),
            .cin      (carry_q[k]),
            .s        (slice_s[k]),
            .cout     (slice_cout[k]),
            .c_msb_in (slice_cmsb[k])
        );
    end

    // Partial sum of each stage with its own slice filled in.
    always_comb begin
        sp_d = sp_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            sp_d[k][k*SLICE +: SLICE] = slice_s[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            a_q     <= '0;
            be_q    <= '0;
            sp_q    <= '0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            a_q[0]     <= a;
            be_q[0]    <= b ^ {WIDTH{sub}};
            carry_q[0] <= ci ^ sub;
            sp_q[0]    <= '0;
            for (int unsigned k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                a_q[k]     <= a_q[k-1];
                be_q[k]    <= be_q[k-1];
                carry_q[k] <= slice_cout[k-1];
                sp_q[k]    <= sp_d[k-1];
            end
        end
    end

    assign s   = sp_d[STAGES-1];
    assign co  = slice_cout[STAGES-1];
    assign ovf = slice_cmsb[STAGES-1] ^ slice_cout[STAGES-1];

    // Already-consumed operand slices and non-final c_msb_in are intentionally dead.
    logic unused_bits;
    assign unused_bits = ^{a_q, be_q, slice_cmsb};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

    localparam int W   = 16;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    bit rand_rdy = 1'b0;

    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_cla_adder #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Golden result packed as {co, ovf, s}.
    function automatic logic [17:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input logic civ, input logic subv);
        logic [W-1:0] bev;
        logic [W:0]   sum;
        logic         ov;
        bev = subv ? ~bv : bv;
        sum = {1'b0, av} + {1'b0, bev} + {16'd0, civ ^ subv};
        ov  = (av[W-1] == bev[W-1]) && (sum[W-1] != av[W-1]);
        return {sum[W], ov, sum[W-1:0]};
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Output monitor: scoreboard pop, stall stability, in_ready relation.
    logic [17:0] prev_out;
    bit          have_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            have_prev = 1'b0;
        end else begin
            check("in_ready_rel", 32'(in_ready), 32'(!out_valid || out_ready));
            if (have_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({co, ovf, s}), 32'(prev_out));
            end
            have_prev = out_valid && !out_ready;
            prev_out  = {co, ovf, s};
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
                else check("result", 32'({co, ovf, s}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Drive one beat starting just after a posedge; returns just after its accept edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ,
                        input logic subv, input logic [17:0] expv);
        int guard = 0;
        in_valid = 1'b1;
        a = av; b = bv; ci = civ; sub = subv;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 200) begin
                check("accept_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        if (in_ready) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 50);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int base;
        logic [W-1:0] ra, rb;
        logic rc, rs;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed cases with spec-given results.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
        wait_out(n);
        check("latency_t1", 32'(n), 32'(LAT));
        drain();
        send(16'h0FFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h1000});
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
        send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        drain();

        // Random back-to-back beats with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Reset with three beats in flight.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
        send(16'h3333, 16'h4444, 1'b0, 1'b0, model(16'h3333, 16'h4444, 1'b0, 1'b0));
        send(16'h5555, 16'h6666, 1'b0, 1'b0, model(16'h5555, 16'h6666, 1'b0, 1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(16'h1234, 16'h4321, 1'b1, 1'b1, model(16'h1234, 16'h4321, 1'b1, 1'b1));
        wait_out(n);
        check("latency_post_rst", 32'(n), 32'(LAT));
        drain();

        // Full rate: 20 beats in, 20 results on consecutive cycles.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    ra = 16'(i * 16'h0C31); rb = 16'(16'hF00F - i);
                    send(ra, rb, i[0], i[1], model(ra, rb, i[0], i[1]));
                end
            end
            begin
                @(posedge clk);
                #1;
                wait_out(n);
                check("latency_full_rate", 32'(n), 32'(LAT));
                for (int i = 1; i < 20; i++) begin
                    @(negedge clk);
                    check("full_rate_consec", 32'(out_valid), 32'd1);
                end
            end
        join
        drain();
        check("full_rate_count", 32'(n_out - base), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
